param_calculator: RTL and testbench
===================================

Name: param_calculator

Overview:
- Parametrised successor to the team's 16-bit button-driven calculator.
- Operand width is set by WIDTH.
- Multiply uses a fixed-latency shift-add engine; divide uses a restoring divider that returns both quotient and remainder.
- Overflow and divide-by-zero are reported as separate flags.
- Adds result chaining: an op button in DONE feeds the result back as the next A operand.
- Sits between the debounced board inputs (switches, SCEN, buttons) and the display/LED logic.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, width of internal iteration counter (derived, not overridden)

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-high reset
In  input  WIDTH  operand entry switches
SCEN  input  1  confirm pulse (single-cycle, from debouncer)
ButU  input  1  select multiply (single-cycle pulse)
ButD  input  1  select divide (single-cycle pulse)
ButR  input  1  select add (single-cycle pulse)
ButL  input  1  select subtract (single-cycle pulse)
Result  output  WIDTH  sum/difference/low product/quotient
Rem  output  WIDTH  division remainder; 0 for other ops
Ovf  output  1  add carry-out, subtract borrow, or non-zero product high half
DivZero  output  1  divide attempted with B==0
Busy  output  1  high in ADD, SUB, MUL, DIV
Done  output  1  high only in DONE
QState  output  9  one-hot state {INITIAL,GET_A,GET_B,GET_OP,ADD,SUB,MUL,DIV,ERR,DONE minus none}: bit0 INITIAL … bit8 DONE, order INITIAL,GET_A,GET_B,GET_OP,ADD,SUB,MUL,DIV,DONE; ERR encoded as QState==0 is illegal, so ERR uses DivZero with state GET_OP-bit clear — see Behaviour

Behaviour:
- State encoding: internal one-hot, 10 states: INITIAL, GET_A, GET_B, GET_OP, ADD, SUB, MUL, DIV, ERR, DONE.
- QState exports the 9 non-ERR bits. In ERR, QState==0 and DivZero==1.
- Reset (async, any time, including mid-MUL/DIV):
  - state=INITIAL.
  - A, B, Result, Rem, counter and working registers = 0.
  - Ovf=DivZero=0.
- INITIAL:
  - Ovf, DivZero cleared every cycle.
  - SCEN -> GET_A.
- GET_A: A<=In every cycle, including the SCEN cycle. SCEN -> GET_B.
- GET_B: B<=In every cycle, including the SCEN cycle. SCEN -> GET_OP.
- GET_OP:
  - Button priority: ButU > ButD > ButR > ButL. No button: stay.
  - On any accepted button: Result<=0, Rem<=0, Ovf<=0, DivZero<=0, counter<=0.
  - ButD with B==0 -> ERR, DivZero<=1.
  - ButD with B!=0 -> DIV.
  - ButU -> MUL, ButR -> ADD, ButL -> SUB.
- ADD: Result<=(A+B) mod 2^WIDTH; Ovf<=carry-out. -> DONE.
- SUB: Result<=(A-B) mod 2^WIDTH; Ovf<=(A<B), unsigned. -> DONE.
- MUL:
  - Unsigned shift-add over a 2*WIDTH-bit product; one multiplier bit per cycle, LSB first.
  - Exactly WIDTH cycles in MUL, then DONE.
  - On exit: Result = product[WIDTH-1:0]; Ovf = |product[2W-1:W].
- DIV:
  - Unsigned restoring division, one quotient bit per cycle, MSB first.
  - Exactly WIDTH cycles in DIV, then DONE.
  - On exit: Result=A/B, Rem=A%B, Ovf=0.
- Latency, counted from the clock edge that samples the op button in GET_OP:
  - ADD/SUB: Done=1 after 2 edges.
  - MUL/DIV: Done=1 after WIDTH+1 edges.
- Result and Rem may change only on GET_OP exit and MUL/DIV/ADD/SUB completion. Intermediate values are not visible on the outputs. Both are held in all other states.
- DONE:
  - Done=1. Outputs held.
  - SCEN -> INITIAL. SCEN has priority over buttons in the same cycle.
  - Chaining: any op button (same priority as GET_OP) -> A<=Result, then acts exactly as GET_OP with the new A and the held B. This covers the B==0 ERR check and the Result/flag clears.
- ERR:
  - Result=0, DivZero=1 held.
  - Buttons ignored. SCEN -> INITIAL.
- Busy is high only in ADD, SUB, MUL, DIV. Inputs are ignored while Busy.
- Simultaneous SCEN and button in GET_OP: the button is acted on; SCEN is ignored.

Test Plan:
- WIDTH=16, A=0xFFFF, B=0x0001, ButR -> Result=0x0000, Ovf=1, Done 2 cycles after the button.
- A=3, B=5, ButL -> Result=0xFFFE, Ovf=1. Then A=5, B=3, ButL -> Result=2, Ovf=0.
- A=300, B=300, ButU -> Done exactly 17 cycles after the button, Result=0x5F90, Ovf=1. Then A=255, B=255 -> Result=65025, Ovf=0.
- A=1000, B=7, ButD -> Result=142, Rem=6, Ovf=0. Then A=9, B=0, ButD -> ERR, QState=0, DivZero=1, Result=0. SCEN -> INITIAL with flags cleared.
- Chain: A=6, B=7, ButU -> Result=42. ButR in DONE -> Result=49. SCEN+ButU together in DONE -> INITIAL.
- Reset asserted 5 cycles into MUL -> immediate INITIAL, all outputs 0, no Done. Repeat with WIDTH=8: A=200, B=3, ButD -> Result=66, Rem=2 after 9 cycles.

Source files
------------

// File: rtl/param_calculator.sv
// param_calculator: button-driven unsigned calculator with add/sub, shift-add multiply and restoring divide
module param_calculator #(
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] In,
   input  logic             SCEN,
   input  logic             ButU,
   input  logic             ButD,
   input  logic             ButR,
   input  logic             ButL,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Rem,
   output logic             Ovf,
   output logic             DivZero,
   output logic             Busy,
   output logic             Done,
   output logic [8:0]       QState
);
   typedef enum logic [9:0] {
      INITIAL = 10'b00_0000_0001,
      GET_A   = 10'b00_0000_0010,
      GET_B   = 10'b00_0000_0100,
      GET_OP  = 10'b00_0000_1000,
      ADD     = 10'b00_0001_0000,
      SUB     = 10'b00_0010_0000,
      MUL     = 10'b00_0100_0000,
      DIV     = 10'b00_1000_0000,
      ERR     = 10'b01_0000_0000,
      DONE    = 10'b10_0000_0000
   } state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   state_t             state;
   logic [WIDTH-1:0]   a, b, mq, dq, dr, dr_next, op_a;
   logic [2*WIDTH-1:0] prod, mc, mul_sum;
   logic [WIDTH:0]     div_try;
   logic               div_ge, btn;
   logic [CNT_W-1:0]   cnt;
   // ERR owns no exported bit, so it reads as QState==0 alongside DivZero
   assign QState = {state[9], state[7:0]};
   assign Busy   = |state[7:4];
   assign Done   = state[9];
   // one multiply/divide step, plus the A operand a new op starts from (Result when chaining)
   always_comb begin
      btn     = ButU | ButD | ButR | ButL;
      op_a    = (state == DONE) ? Result : a;
      mul_sum = prod + (mq[0] ? mc : '0);
      div_try = {dr, dq[WIDTH-1]};
      div_ge  = div_try >= {1'b0, b};
      dr_next = WIDTH'(div_ge ? div_try - {1'b0, b} : div_try);
   end
   // control FSM; Result/Rem are written only when an op starts or completes
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= INITIAL;
         a       <= '0;
         b       <= '0;
         Result  <= '0;
         Rem     <= '0;
         Ovf     <= 1'b0;
         DivZero <= 1'b0;
         cnt     <= '0;
         prod    <= '0;
         mc      <= '0;
         mq      <= '0;
         dr      <= '0;
         dq      <= '0;
      end else begin
         case (state)
            INITIAL: begin
               Ovf     <= 1'b0;
               DivZero <= 1'b0;
               if (SCEN) state <= GET_A;
            end
            GET_A: begin
               a <= In;
               if (SCEN) state <= GET_B;
            end
            GET_B: begin
               b <= In;
               if (SCEN) state <= GET_OP;
            end
            GET_OP, DONE: begin
               if (state == DONE && SCEN) begin
                  state   <= INITIAL;
                  Ovf     <= 1'b0;
                  DivZero <= 1'b0;
               end else if (btn) begin
                  if (state == DONE) a <= Result;
                  Result  <= '0;
                  Rem     <= '0;
                  Ovf     <= 1'b0;
                  DivZero <= 1'b0;
                  cnt     <= '0;
                  prod    <= '0;
                  mc      <= {{WIDTH{1'b0}}, b};
                  mq      <= op_a;
                  dr      <= '0;
                  dq      <= op_a;
                  if (ButU) state <= MUL;
                  else if (ButD) begin
                     state   <= (b == '0) ? ERR : DIV;
                     DivZero <= (b == '0);
                  end else state <= ButR ? ADD : SUB;
               end
            end
            ADD: begin
               {Ovf, Result} <= {1'b0, a} + {1'b0, b};
               state         <= DONE;
            end
            SUB: begin
               Result <= a - b;
               Ovf    <= a < b;
               state  <= DONE;
            end
            MUL: begin
               prod <= mul_sum;
               mc   <= mc << 1;
               mq   <= mq >> 1;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  Result <= mul_sum[WIDTH-1:0];
                  Ovf    <= |mul_sum[2*WIDTH-1:WIDTH];
                  state  <= DONE;
               end
            end
            DIV: begin
               dr  <= dr_next;
               dq  <= {dq[WIDTH-2:0], div_ge};
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  Result <= {dq[WIDTH-2:0], div_ge};
                  Rem    <= dr_next;
                  Ovf    <= 1'b0;
                  state  <= DONE;
               end
            end
            ERR: begin
               if (SCEN) begin
                  state   <= INITIAL;
                  Ovf     <= 1'b0;
                  DivZero <= 1'b0;
               end
            end
            default: state <= INITIAL;
         endcase
      end
   end
endmodule

// File: tb/tb_param_calculator.sv
// tb_param_calculator: WIDTH=16 and WIDTH=8 calculators on shared stimulus, checked against a behavioural model
module tb_param_calculator;
   localparam int S_I = 0, S_A = 1, S_B = 2, S_OP = 3, S_BZ = 4, S_ER = 5, S_DN = 6;
   logic        clk = 1'b0;
   logic        rst, scen, bu, bd, br, bl;
   logic [15:0] in_sw;
   logic [15:0] res16, rem16;
   logic [7:0]  res8, rem8;
   logic        ovf16, dz16, busy16, done16, ovf8, dz8, busy8, done8;
   logic [8:0]  q16, q8;
   logic        ready = 1'b0;
   int          checks = 0, errors = 0;
   int          l16, l8;
   int          wid[2] = '{16, 8};
   int          m_st[2], m_op[2], m_left[2], m_ovf[2], m_dz[2];
   longint      m_a[2], m_b[2], m_res[2], m_rem[2];
   longint      t_msk, t_p;

   param_calculator #(.WIDTH(16)) dut16 (
      .Clk(clk), .Reset(rst), .In(in_sw), .SCEN(scen), .ButU(bu), .ButD(bd), .ButR(br), .ButL(bl),
      .Result(res16), .Rem(rem16), .Ovf(ovf16), .DivZero(dz16), .Busy(busy16), .Done(done16), .QState(q16));
   param_calculator #(.WIDTH(8)) dut8 (
      .Clk(clk), .Reset(rst), .In(in_sw[7:0]), .SCEN(scen), .ButU(bu), .ButD(bd), .ButR(br), .ButL(bl),
      .Result(res8), .Rem(rem8), .Ovf(ovf8), .DivZero(dz8), .Busy(busy8), .Done(done8), .QState(q8));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   // transaction-level model: operands latched, results computed with plain arithmetic on completion
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         t_msk = (longint'(1) << wid[k]) - 1;
         if (rst) begin
            m_st[k] = S_I; m_a[k] = 0; m_b[k] = 0; m_res[k] = 0; m_rem[k] = 0; m_ovf[k] = 0; m_dz[k] = 0;
         end else begin
            case (m_st[k])
               S_I: begin m_ovf[k] = 0; m_dz[k] = 0; if (scen) m_st[k] = S_A; end
               S_A: begin m_a[k] = longint'(in_sw) & t_msk; if (scen) m_st[k] = S_B; end
               S_B: begin m_b[k] = longint'(in_sw) & t_msk; if (scen) m_st[k] = S_OP; end
               S_OP, S_DN: begin
                  if (m_st[k] == S_DN && scen) begin
                     m_st[k] = S_I; m_ovf[k] = 0; m_dz[k] = 0;
                  end else if (bu | bd | br | bl) begin
                     if (m_st[k] == S_DN) m_a[k] = m_res[k];
                     m_res[k] = 0; m_rem[k] = 0; m_ovf[k] = 0; m_dz[k] = 0;
                     m_op[k] = bu ? 2 : bd ? 3 : br ? 0 : 1;
                     if (m_op[k] == 3 && m_b[k] == 0) begin
                        m_st[k] = S_ER; m_dz[k] = 1;
                     end else begin
                        m_st[k] = S_BZ; m_left[k] = (m_op[k] >= 2) ? wid[k] : 1;
                     end
                  end
               end
               S_BZ: begin
                  m_left[k]--;
                  if (m_left[k] == 0) begin
                     case (m_op[k])
                        0: begin t_p = m_a[k] + m_b[k]; m_res[k] = t_p & t_msk; m_ovf[k] = (t_p > t_msk) ? 1 : 0; end
                        1: begin m_res[k] = (m_a[k] - m_b[k]) & t_msk; m_ovf[k] = (m_a[k] < m_b[k]) ? 1 : 0; end
                        2: begin t_p = m_a[k] * m_b[k]; m_res[k] = t_p & t_msk; m_ovf[k] = (t_p > t_msk) ? 1 : 0; end
                        default: begin m_res[k] = m_a[k] / m_b[k]; m_rem[k] = m_a[k] % m_b[k]; m_ovf[k] = 0; end
                     endcase
                     m_st[k] = S_DN;
                  end
               end
               S_ER: if (scen) begin m_st[k] = S_I; m_ovf[k] = 0; m_dz[k] = 0; end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [31:0] exp_q(input int k);
      case (m_st[k])
         S_I:  return 1;
         S_A:  return 2;
         S_B:  return 4;
         S_OP: return 8;
         S_BZ: return 32'(16 << m_op[k]);
         S_DN: return 256;
         default: return 0;
      endcase
   endfunction

   task automatic cmp(input string nm, input int k, input logic [31:0] q, input logic [31:0] bz,
                      input logic [31:0] dn, input logic [31:0] dz, input logic [31:0] ov,
                      input logic [31:0] rs, input logic [31:0] rm);
      logic [31:0] eq, ebz, edn;
      eq  = exp_q(k);
      ebz = (m_st[k] == S_BZ) ? 1 : 0;
      edn = (m_st[k] == S_DN) ? 1 : 0;
      checks++;
      if (q !== eq || bz !== ebz || dn !== edn || dz !== 32'(m_dz[k]) || ov !== 32'(m_ovf[k]) ||
          rs !== 32'(m_res[k]) || rm !== 32'(m_rem[k])) begin
         errors++;
         $display("FAIL %s t=%0t got q=%0h busy=%0d done=%0d dz=%0d ovf=%0d res=%0h rem=%0h expected q=%0h busy=%0d done=%0d dz=%0d ovf=%0d res=%0h rem=%0h",
                  nm, $time, q, bz, dn, dz, ov, rs, rm, eq, ebz, edn, m_dz[k], m_ovf[k], m_res[k], m_rem[k]);
      end
   endtask

   // every cycle, both DUTs must match the model
   always @(negedge clk) begin
      if (ready) begin
         cmp("dut16", 0, 32'(q16), 32'(busy16), 32'(done16), 32'(dz16), 32'(ovf16), 32'(res16), 32'(rem16));
         cmp("dut8", 1, 32'(q8), 32'(busy8), 32'(done8), 32'(dz8), 32'(ovf8), 32'(res8), 32'(rem8));
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic pulse(input logic s, input logic u, input logic d, input logic r, input logic l);
      scen = s; bu = u; bd = d; br = r; bl = l;
      @(negedge clk);
      scen = 0; bu = 0; bd = 0; br = 0; bl = 0;
   endtask

   task automatic enter(input int av, input int bv);
      pulse(1, 0, 0, 0, 0);
      in_sw = 16'(av);
      pulse(1, 0, 0, 0, 0);
      in_sw = 16'(bv);
      pulse(1, 0, 0, 0, 0);
   endtask

   task automatic wait_done(output int o16, output int o8);
      int n;
      n = 1; o16 = 0; o8 = 0;
      while (n < 40) begin
         if (done16 && o16 == 0) o16 = n;
         if (done8 && o8 == 0) o8 = n;
         if (o16 != 0 && o8 != 0) break;
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      rst = 1; in_sw = 0; scen = 0; bu = 0; bd = 0; br = 0; bl = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      ready = 1;
      chk("rst_q16", 32'(q16), 1);
      chk("rst_res16", 32'(res16), 0);
      chk("rst_q8", 32'(q8), 1);
      enter(16'hFFFF, 1); pulse(0, 0, 0, 1, 0); wait_done(l16, l8);
      chk("add_lat", l16, 2);
      chk("add_res", 32'(res16), 0);
      chk("add_ovf", 32'(ovf16), 1);
      pulse(1, 0, 0, 0, 0);
      enter(3, 5); pulse(0, 0, 0, 0, 1); wait_done(l16, l8);
      chk("sub_res", 32'(res16), 32'hFFFE);
      chk("sub_ovf", 32'(ovf16), 1);
      pulse(1, 0, 0, 0, 0);
      enter(5, 3); pulse(0, 0, 0, 0, 1); wait_done(l16, l8);
      chk("sub2_res", 32'(res16), 2);
      chk("sub2_ovf", 32'(ovf16), 0);
      pulse(1, 0, 0, 0, 0);
      enter(300, 300); pulse(0, 1, 0, 0, 0); wait_done(l16, l8);
      chk("mul_lat", l16, 17);
      chk("mul_res", 32'(res16), 32'h5F90);
      chk("mul_ovf", 32'(ovf16), 1);
      pulse(1, 0, 0, 0, 0);
      enter(255, 255); pulse(0, 1, 0, 0, 0); wait_done(l16, l8);
      chk("mul2_res", 32'(res16), 65025);
      chk("mul2_ovf", 32'(ovf16), 0);
      pulse(1, 0, 0, 0, 0);
      enter(1000, 7); pulse(0, 0, 1, 0, 0); wait_done(l16, l8);
      chk("div_lat", l16, 17);
      chk("div_res", 32'(res16), 142);
      chk("div_rem", 32'(rem16), 6);
      chk("div8_res", 32'(res8), 33);
      chk("div8_rem", 32'(rem8), 1);
      pulse(1, 0, 0, 0, 0);
      enter(9, 0); pulse(0, 0, 1, 0, 0);
      chk("err_q", 32'(q16), 0);
      chk("err_dz", 32'(dz16), 1);
      chk("err_res", 32'(res16), 0);
      pulse(0, 1, 1, 1, 1);
      chk("err_btn_q", 32'(q16), 0);
      pulse(1, 0, 0, 0, 0);
      chk("err_exit_q", 32'(q16), 1);
      chk("err_exit_dz", 32'(dz16), 0);
      enter(6, 7); pulse(0, 1, 0, 0, 0); wait_done(l16, l8);
      chk("chain_mul", 32'(res16), 42);
      pulse(0, 0, 0, 1, 0); wait_done(l16, l8);
      chk("chain_add", 32'(res16), 49);
      chk("chain_add8", 32'(res8), 49);
      pulse(1, 1, 0, 0, 0);
      chk("scen_prio_q", 32'(q16), 1);
      chk("scen_prio_res", 32'(res16), 49);
      enter(300, 300); pulse(0, 1, 0, 0, 0);
      repeat (4) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("rstmul_q", 32'(q16), 1);
      chk("rstmul_busy", 32'(busy16), 0);
      chk("rstmul_done", 32'(done16), 0);
      chk("rstmul_out", {res16, rem16}, 0);
      chk("rstmul_flags", {dz16, ovf16}, 0);
      @(negedge clk);
      rst = 0;
      enter(200, 3); pulse(0, 0, 1, 0, 0); wait_done(l16, l8);
      chk("div8_lat", l8, 9);
      chk("div8b_res", 32'(res8), 66);
      chk("div8b_rem", 32'(rem8), 2);
      pulse(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         in_sw = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         scen  = ($urandom_range(0, 4) == 0);
         bu    = ($urandom_range(0, 9) == 0);
         bd    = ($urandom_range(0, 9) == 0);
         br    = ($urandom_range(0, 9) == 0);
         bl    = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1;
            #2 rst = 0;
         end
      end
      scen = 0; bu = 0; bd = 0; br = 0; bl = 0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
